time_counter: RTL

- Consumes the one_minute pulse from the time generator and keeps current time of day as four BCD digits, 24-hour format (HH:MM).
- Accepts a new current time from the keypad/controller path, validates it, and loads it.
- On a successful load, issues a one-cycle reset_count pulse back to the time generator so the next minute boundary is exactly 60 s (or one fastwatch tick) after the load.
- Sits between the time generator and the alarm comparator/display driver.

---
 rtl/time_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/time_counter.sv
// Time-of-day counter: four BCD digits, 24-hour HH:MM.
// Advances on the one_minute tick, accepts validated loads of a new time,
// and pulses reset_count after an accepted load so the time generator
// restarts its minute interval from the load point.
module time_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       reset_count,
  output logic       load_error
);

  logic       load_ok;
  logic [3:0] inc_ms_hr;
  logic [3:0] inc_ls_hr;
  logic [3:0] inc_ms_min;
  logic [3:0] inc_ls_min;

  // Range check on the requested time; hours 20..23 need the ls_hr<=3 cap.
  always_comb begin
    load_ok = (new_current_time_ms_hr  <= 4'd2) &&
              (new_current_time_ls_hr  <= 4'd9) &&
              !((new_current_time_ms_hr == 4'd2) && (new_current_time_ls_hr > 4'd3)) &&
              (new_current_time_ms_min <= 4'd5) &&
              (new_current_time_ls_min <= 4'd9);
  end

  // Next time after one minute, rippling the carry digit by digit in BCD.
  always_comb begin
    inc_ms_hr  = current_time_ms_hr;
    inc_ls_hr  = current_time_ls_hr;
    inc_ms_min = current_time_ms_min;
    inc_ls_min = current_time_ls_min + 4'd1;
    if (current_time_ls_min == 4'd9) begin
      inc_ls_min = 4'd0;
      if (current_time_ms_min == 4'd5) begin
        inc_ms_min = 4'd0;
        if ((current_time_ms_hr == 4'd2) && (current_time_ls_hr == 4'd3)) begin
          inc_ms_hr = 4'd0;
          inc_ls_hr = 4'd0;
        end else if (current_time_ls_hr == 4'd9) begin
          inc_ls_hr = 4'd0;
          inc_ms_hr = current_time_ms_hr + 4'd1;
        end else begin
          inc_ls_hr = current_time_ls_hr + 4'd1;
        end
      end else begin
        inc_ms_min = current_time_ms_min + 4'd1;
      end
    end
  end

  // Time register and status pulses: reset > accepted load > tick > hold.
  // A rejected load still lets a coincident tick through.
  always_ff @(posedge clock) begin
    if (reset) begin
      current_time_ms_hr  <= 4'd0;
      current_time_ls_hr  <= 4'd0;
      current_time_ms_min <= 4'd0;
      current_time_ls_min <= 4'd0;
      reset_count         <= 1'b0;
      load_error          <= 1'b0;
    end else begin
      reset_count <= 1'b0;
      load_error  <= 1'b0;
      if (load_new_c && load_ok) begin
        current_time_ms_hr  <= new_current_time_ms_hr;
        current_time_ls_hr  <= new_current_time_ls_hr;
        current_time_ms_min <= new_current_time_ms_min;
        current_time_ls_min <= new_current_time_ls_min;
        reset_count         <= 1'b1;
      end else begin
        load_error <= load_new_c;
        if (one_minute) begin
          current_time_ms_hr  <= inc_ms_hr;
          current_time_ls_hr  <= inc_ls_hr;
          current_time_ms_min <= inc_ms_min;
          current_time_ls_min <= inc_ls_min;
        end
      end
    end
  end

endmodule
